// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: funct3 codes, op and FSM enums.
// The divider is only built when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    OP_MUL    = F3_MUL,
    OP_MULH   = F3_MULH,
    OP_MULHSU = F3_MULHSU,
    OP_MULHU  = F3_MULHU,
    OP_DIV    = F3_DIV,
    OP_DIVU   = F3_DIVU,
    OP_REM    = F3_REM,
    OP_REMU   = F3_REMU
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One CALC cycle: UNROLL chained single-bit shift-add (multiply) or restoring (divide) iterations.
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN-1:0] hi_c [UNROLL+1];
  logic [XLEN-1:0] lo_c [UNROLL+1];

  assign hi_c[0] = hi_i;
  assign lo_c[0] = lo_i;

  genvar gi;
  generate
    for (gi = 0; gi < UNROLL; gi++) begin : g_bit
      // Multiply: {hi,lo} holds partial product above the unconsumed multiplier bits.
      logic [XLEN:0] mul_sum;
      assign mul_sum = {1'b0, hi_c[gi]} + (lo_c[gi][0] ? {1'b0, opnd_i} : '0);
`ifdef MULDIV_DIV_EN
      logic [XLEN:0] sh;
      logic [XLEN:0] diff;
      assign sh   = {hi_c[gi], lo_c[gi][XLEN-1]};
      assign diff = sh - {1'b0, opnd_i};
      assign hi_c[gi+1] = !is_div_i ? mul_sum[XLEN:1] :
                          (diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0]);
      assign lo_c[gi+1] = !is_div_i ? {mul_sum[0], lo_c[gi][XLEN-1:1]} :
                          {lo_c[gi][XLEN-2:0], ~diff[XLEN]};
`else
      assign hi_c[gi+1] = mul_sum[XLEN:1];
      assign lo_c[gi+1] = {mul_sum[0], lo_c[gi][XLEN-1:1]};
`endif
    end
  endgenerate

`ifndef MULDIV_DIV_EN
  logic unused_is_div;
  assign unused_is_div = is_div_i;
`endif

  assign hi_o = hi_c[UNROLL];
  assign lo_o = lo_c[UNROLL];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: IDLE->PREP->CALC->FIXUP->DONE, XLEN/UNROLL CALC cycles.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops finish flagged illegal_op.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal_op
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = $clog2(STEPS + 1);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d, ill_q, ill_d;
  logic              done_q, done_d, illegal_q, illegal_d;

  logic [XLEN-1:0]   step_hi, step_lo, a_mag, b_mag, fix_val;
  logic [2*XLEN-1:0] prod, prod_s;
  logic              a_sgn, b_sgn, a_neg, b_neg, neg_c;

  muldiv_step #(.XLEN(XLEN), .UNROLL(UNROLL)) u_step (
    .is_div_i (op_q[2]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Operand magnitudes and result sign; MULHSU treats only a as signed.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_q)
      OP_MULH, OP_DIV, OP_REM: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      OP_MULHSU:               a_sgn = 1'b1;
      default:                 ;
    endcase
    a_neg = a_sgn & a_q[XLEN-1];
    b_neg = b_sgn & b_q[XLEN-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    neg_c = (op_q == OP_REM) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    prod    = {hi_q, lo_q};
    prod_s  = neg_q ? -prod : prod;
    fix_val = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    if (op_q[2]) begin
      fix_val = op_q[1] ? hi_q : lo_q;
      fix_val = neg_q ? -fix_val : fix_val;
    end
`endif
  end

`ifdef MULDIV_DIV_EN
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] fast_val;
  assign div_zero = (b_q == '0);
  assign div_ovf  = a_sgn && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
  assign fast_val = op_q[1] ? (div_zero ? a_q : '0) : (div_zero ? '1 : a_q);
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    ill_d     = ill_q;
    result_d  = result_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        op_d    = op_e'(op);
        a_d     = a;
        b_d     = b;
        state_d = S_PREP;
      end
      S_PREP: begin
        hi_d    = '0;
        lo_d    = a_mag;
        opnd_d  = b_mag;
        neg_d   = neg_c;
        cnt_d   = '0;
        ill_d   = 1'b0;
        state_d = S_CALC;
        if (op_q[2]) begin
`ifdef MULDIV_DIV_EN
          if (div_zero || div_ovf) begin
            lo_d    = fast_val;
            state_d = S_DONE;
          end
`else
          lo_d    = '0;
          ill_d   = 1'b1;
          state_d = S_DONE;
`endif
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        lo_d    = fix_val;
        state_d = S_DONE;
      end
      S_DONE: begin
        result_d  = lo_q;
        done_d    = 1'b1;
        illegal_d = ill_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush also drops a start presented in IDLE.
    if (flush) begin
      state_d   = S_IDLE;
      result_d  = result_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      result_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      ill_q     <= ill_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    a_q    <= a_d;
    b_q    <= b_d;
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    opnd_q <= opnd_d;
    neg_q  <= neg_d;
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign result     = result_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (UNROLL=1 and UNROLL=4 instances).
// Divide expectations follow whether MULDIV_DIV_EN is defined.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int DLAT = DIV_EN ? 35 : 2;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, start4 = 1'b0, flush = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, illegal_op, busy4, done4, illegal4;
  logic [31:0] result, result4;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .result(result), .illegal_op(illegal_op)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy4), .done(done4), .result(result4), .illegal_op(illegal4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Issue one op; lat = edges from the accepting edge to done (-1 on timeout).
  task automatic run(input bit sel, input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                     input bit poke, output int lat, output logic [31:0] res, output logic ill,
                     output bit busy_ok);
    lat = -1; res = 'x; ill = 1'bx; busy_ok = 1'b1;
    @(negedge clk);
    op = o; a = aa; b = bb;
    if (sel) start4 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start4 = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (poke && k == 5) begin start = 1'b1; op = 3'b011; a = 32'h1234; b = 32'h99; end
      if (poke && k == 6) begin start = 1'b0; op = o; a = aa; b = bb; end
      @(posedge clk); #1;
      if (sel ? done4 : done) begin
        lat = k;
        res = sel ? result4 : result;
        ill = sel ? illegal4 : illegal_op;
        if (sel ? busy4 : busy) busy_ok = 1'b0;
        break;
      end
      if (!(sel ? busy4 : busy)) busy_ok = 1'b0;
    end
  endtask

  task automatic vec(input string tag, input bit sel, input logic [2:0] o, input logic [31:0] aa,
                     input logic [31:0] bb, input bit poke, input logic [31:0] exp_res,
                     input int exp_lat, input bit exp_ill);
    int lat; logic [31:0] res; logic ill; bit bok;
    run(sel, o, aa, bb, poke, lat, res, ill, bok);
    check({tag, ".res"}, res, exp_res);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".ill"}, 32'(ill), 32'(exp_ill));
    check({tag, ".busy"}, 32'(bok), 32'd1);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", result, 32'h0);
    check("rst.illegal", 32'(illegal_op), 32'd0);
    reset = 1'b1;

    vec("mul",     0, 3'b000, 32'd7,        32'hFFFFFFFD, 0, 32'hFFFFFFEB, 35, 0);
    @(posedge clk); #1;
    check("mul.done_pulse", 32'(done), 32'd0);
    check("mul.held", result, 32'hFFFFFFEB);
    vec("mulhu",   0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 35, 0);
    vec("mulh",    0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000000, 35, 0);
    vec("mulhu_u4",1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 11, 0);
    vec("mul_u4",  1, 3'b000, 32'd7,        32'hFFFFFFFD, 0, 32'hFFFFFFEB, 11, 0);
    vec("mulhsu",  0, 3'b010, 32'hFFFFFFFF, 32'd2,        0, 32'hFFFFFFFF, 35, 0);

    // Flush in CALC: no done, result keeps the MULHSU value.
    @(negedge clk);
    op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush.busy", 32'(busy), 32'd0);
    check("flush.done", 32'(done), 32'd0);
    check("flush.result", result, 32'hFFFFFFFF);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    check("flush.nodone", 32'(seen), 32'd0);
    vec("mul_poke", 0, 3'b000, 32'd3, 32'd5, 1, 32'd15, 35, 0);

    // Start together with flush in IDLE is dropped.
    @(negedge clk);
    op = 3'b000; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("sflush.busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    check("sflush.nodone", 32'(seen), 32'd0);
    check("sflush.result", result, 32'd15);

    vec("div_ovf",  0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 0, DIV_EN ? 32'h80000000 : 32'h0, 2, !DIV_EN);
    vec("rem_ovf",  0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0, 2, !DIV_EN);
    vec("divu_z",   0, 3'b101, 32'd5, 32'd0, 0, DIV_EN ? 32'hFFFFFFFF : 32'h0, 2, !DIV_EN);
    vec("remu_z",   0, 3'b111, 32'd5, 32'd0, 0, DIV_EN ? 32'd5 : 32'h0, 2, !DIV_EN);
    vec("rem_m7",   0, 3'b110, 32'hFFFFFFF9, 32'd2, 0, DIV_EN ? 32'hFFFFFFFF : 32'h0, DLAT, !DIV_EN);
    vec("div_m7",   0, 3'b100, 32'hFFFFFFF9, 32'd2, 0, DIV_EN ? 32'hFFFFFFFD : 32'h0, DLAT, !DIV_EN);
    vec("div_7m2",  0, 3'b100, 32'd7, 32'hFFFFFFFE, 0, DIV_EN ? 32'hFFFFFFFD : 32'h0, DLAT, !DIV_EN);
    vec("rem_7m2",  0, 3'b110, 32'd7, 32'hFFFFFFFE, 0, DIV_EN ? 32'd1 : 32'h0, DLAT, !DIV_EN);
    vec("divu_100", 0, 3'b101, 32'd100, 32'd7, 0, DIV_EN ? 32'd14 : 32'h0, DLAT, !DIV_EN);
    vec("remu_100", 0, 3'b111, 32'd100, 32'd7, 0, DIV_EN ? 32'd2 : 32'h0, DLAT, !DIV_EN);
    vec("mul_after",0, 3'b000, 32'h00010000, 32'h00010001, 0, 32'h00010000, 35, 0);

    // Reset mid-CALC, then start on the first edge after release.
    @(negedge clk);
    op = 3'b000; a = 32'd11; b = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("rstcalc.busy_before", 32'(busy), 32'd1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("rstcalc.busy", 32'(busy), 32'd0);
    check("rstcalc.result", result, 32'h0);
    check("rstcalc.done", 32'(done), 32'd0);
    reset = 1'b1;
    vec("mul_postrst", 0, 3'b000, 32'd2, 32'd3, 0, 32'd6, 35, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter UNROLL, default 1, iteration bits per cycle; legal values 1, 2, 4; XLEN divisible by UNROLL.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-006 SHALL have port op  input  3  funct3 encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (000..111).
REQ-007 SHALL have ports a, b  input  XLEN  rs1/rs2 operands, sampled at acceptance.
REQ-008 SHALL have port flush  input  1  kill the in-flight operation (hazard unit FlushE).
REQ-009 SHALL have port busy  output  1  operation in flight; drives the hazard unit MulBusy stall.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port result  output  XLEN  final value; held until the next done.
REQ-012 SHALL have port illegal_op  output  1  qualifies done; set when a divide op is issued with the divider compiled out.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, CALC, FIXUP, DONE.
REQ-014 SHALL accept start in IDLE only; latch op, a, b; move to PREP; busy=1 from the following cycle.
REQ-015 SHALL, in PREP, form operand magnitudes and result sign per op signedness; MULHSU treats only a as signed.
REQ-016 SHALL, in CALC, perform radix-2^UNROLL shift-add multiply or restoring divide for exactly XLEN/UNROLL cycles.
REQ-017 SHALL, in FIXUP, apply sign correction and select the low/high product half, quotient or remainder.
REQ-018 SHALL, in DONE, assert done for one cycle, update result, and return to IDLE with busy=0 in the same cycle.
REQ-019 SHALL give normal latency of XLEN/UNROLL+3 cycles from the accepting edge to done.
REQ-020 SHALL, on divide-by-zero, skip CALC/FIXUP (PREP->DONE): quotient all-ones, remainder = a; done 2 cycles after acceptance.
REQ-021 SHALL, on signed overflow (a = -2^(XLEN-1), b = -1, DIV/REM), take the same fast path: quotient = a, remainder = 0.
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL, on flush in any non-IDLE state, enter IDLE next cycle: no done, result unchanged.
REQ-024 SHALL, with start and flush both high in IDLE, drop the start (flush wins).
REQ-025 SHALL sign a remainder like the dividend and a quotient like a XOR b (truncating division).

Reset
REQ-026 SHALL, while reset=0 at a clock edge, force IDLE, busy=0, done=0, illegal_op=0, result=0, aborting any operation.
REQ-027 SHALL accept start on the first edge after reset returns high.

Configuration
REQ-028 SHALL use macro MULDIV_DIV_EN; when defined, the divider and all divide ops are built as specified.
REQ-029 SHALL, when MULDIV_DIV_EN is undefined, omit divider logic; op 1xx takes PREP->DONE with result=0 and illegal_op=1 alongside done; multiply is unchanged.

Structure
REQ-030 SHALL define the op enum, FSM state enum and funct3 constants in shared package muldiv_pkg.
REQ-031 SHALL contain one sub-module, muldiv_step: combinational UNROLL-bit multiply/divide iteration, instantiated once.

Verification (XLEN=32, UNROLL=1 unless noted)
REQ-032 SHALL cover: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 35 cycles after acceptance, busy high throughout.
REQ-033 SHALL cover: MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; UNROLL=4 -> done at cycle 11.
REQ-034 SHALL cover: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at cycle 2; REM same operands -> 0; DIVU a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5.
REQ-035 SHALL cover: REM a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFF; DIV same operands -> 0xFFFFFFFD.
REQ-036 SHALL cover: flush at cycle 10 of a MUL -> no done, busy=0 next cycle, prior result kept; next start then completes normally.
REQ-037 SHALL cover: reset=0 mid-CALC -> busy=0, result=0 next cycle; with MULDIV_DIV_EN undefined, DIV -> done at cycle 2, illegal_op=1, result=0.
